// File: rtl/mips16_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding
// and the fixed four-byte instruction word geometry.
package mips16_pkg;

    localparam int INSTR_W         = 32;
    localparam int BYTES_PER_INSTR = 4;
    localparam int BYTE_IDX_W      = $clog2(BYTES_PER_INSTR);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/instr_word_packer.sv
// Shifts program bytes MSB-first into a 32-bit instruction word and flags the
// cycle in which the fourth byte of a word is taken.
module instr_word_packer
    import mips16_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_complete
);

    logic [INSTR_W-1:0]    word_q, word_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    // Four shifts fully replace the word, so byte 0 ends up in [31:24].
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (shift_en) begin
            word_d = {word_q[INSTR_W-9:0], byte_in};
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word          = word_q;
    assign word_complete = shift_en && (idx_q == BYTE_IDX_W'(BYTES_PER_INSTR - 1));

endmodule

// File: rtl/instr_loader.sv
// Loads a program byte stream into instruction memory while holding the CPU
// stalled; optional trailing checksum byte enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  word_count,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_stall,
    output logic               busy,
    output logic               load_done,
    output logic               chk_err,
    output logic [2:0]         dbg_state
);
    import mips16_pkg::*;

    // Byte handshake: a byte moves on a rising edge where byte_valid and
    // byte_ready are both high; byte_ready is high only while a byte can be used.

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] wc_q, wc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_addr;
    logic              stall_q, stall_d;
    logic              pk_clear;
    logic              pk_shift;
    logic              pk_word_complete;
    logic [31:0]       pk_word;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       chk_err_q, chk_err_d;
`endif

    instr_word_packer u_packer (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear         (pk_clear),
        .shift_en      (pk_shift),
        .byte_in       (byte_in),
        .word          (pk_word),
        .word_complete (pk_word_complete)
    );

    // word_count of 0 wraps to all-ones here, giving 2^ADDR_W words.
    assign last_addr = wc_q - ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        wc_d       = wc_q;
        addr_d     = addr_q;
        stall_d    = stall_q;
        pk_clear   = 1'b0;
        pk_shift   = 1'b0;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        load_done  = 1'b0;
        busy       = (state_q != IDLE);
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        chk_err_d  = chk_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RECV;
                    wc_d     = word_count;
                    addr_d   = '0;
                    pk_clear = 1'b1;
                    stall_d  = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d    = '0;
                    chk_err_d = 1'b0;
`endif
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    pk_shift = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (pk_word_complete) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                if (addr_q == last_addr) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = RECV;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    chk_err_d = (byte_in != csum_q);
                    state_d   = DONE;
                end
            end
`endif
            DONE: begin
                load_done = 1'b1;
                state_d   = IDLE;
                // A program that failed its checksum is never released.
`ifdef INSTR_LOADER_CHECKSUM_EN
                stall_d = chk_err_q;
`else
                stall_d = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wc_q    <= '0;
            addr_q  <= '0;
            stall_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            addr_q  <= addr_d;
            stall_q <= stall_d;
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum_q    <= '0;
            chk_err_q <= 1'b0;
        end else begin
            csum_q    <= csum_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign imem_addr  = addr_q;
    assign imem_wdata = INSTR_W'(pk_word);
    assign cpu_stall  = stall_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: write scoreboard, reset, stall, wrap and
// ignored-start scenarios, plus checksum cases when the option is built in.
module tb_instr_loader;

    localparam int ADDR_W = 4;
    localparam int SB_W   = ADDR_W + 32;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] word_count = '0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_stall;
    logic              busy;
    logic              load_done;
    logic              chk_err;
    logic [2:0]        dbg_state;

    instr_loader #(.ADDR_W(ADDR_W), .INSTR_W(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_stall  (cpu_stall),
        .busy       (busy),
        .load_done  (load_done),
        .chk_err    (chk_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int               test_cnt = 0;
    int               fail_cnt = 0;
    int               we_cnt = 0;
    int               done_cnt = 0;
    logic [SB_W-1:0]  exp_q[$];
    logic [SB_W-1:0]  mon_exp;
    logic [7:0]       csum = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (imem_we) begin
            we_cnt++;
            check("stall_during_write", cpu_stall, 1);
            if (exp_q.size() == 0) begin
                check("sb_expected_write_pending", exp_q.size(), 1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write_addr", imem_addr, mon_exp[SB_W-1:32]);
                check("write_data", imem_wdata, mon_exp[31:0]);
            end
        end
        if (load_done) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        we_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic start_load(input logic [ADDR_W-1:0] wc);
        word_count = wc;
        start = 1'b1;
        tick();
        start = 1'b0;
        csum = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) tick();
        byte_in = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("byte_accept_timeout", byte_ready, 1);
        tick();
        byte_valid = 1'b0;
        csum = csum ^ b;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
        check("write_latency", imem_we, 1);
    endtask

    task automatic send_checksum(input logic [7:0] b);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(b, 0);
`else
        byte_in = b;
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("idle_timeout", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},        imem_we, 0);
        check({tag, "_addr"},      imem_addr, 0);
        check({tag, "_wdata"},     imem_wdata, 0);
        check({tag, "_ready"},     byte_ready, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      load_done, 0);
        check({tag, "_chk_err"},   chk_err, 0);
        check({tag, "_stall"},     cpu_stall, 1);
        check({tag, "_state"},     dbg_state, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] pat;

    initial begin
        reset_n = 1'b0;
        repeat (2) tick();
        check_reset_outputs("por");
        reset_n = 1'b1;
        tick();
        check("stall_after_reset", cpu_stall, 1);

        // Two-word load, back-to-back bytes
        clear_counts();
        exp_q.push_back({4'd0, 32'h20010005});
        exp_q.push_back({4'd1, 32'h8C030000});
        start_load(4'd2);
        check("t1_busy", busy, 1);
        check("t1_stall", cpu_stall, 1);
        check("t1_ready", byte_ready, 1);
        send_word(32'h20010005, 0);
        send_word(32'h8C030000, 0);
        send_checksum(csum);
        wait_idle();
        check("t1_we_cnt", we_cnt, 2);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_stall_released", cpu_stall, 0);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_addr_hold", imem_addr, 1);
        check("t1_chk_err", chk_err, 0);

        // Same load with 3-cycle gaps before every byte
        clear_counts();
        exp_q.push_back({4'd0, 32'h20010005});
        exp_q.push_back({4'd1, 32'h8C030000});
        start_load(4'd2);
        send_word(32'h20010005, 3);
        send_word(32'h8C030000, 3);
        send_checksum(csum);
        wait_idle();
        check("t2_we_cnt", we_cnt, 2);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_sb_empty", exp_q.size(), 0);
        check("t2_stall_released", cpu_stall, 0);

        // word_count=0 loads all 16 words; address only returns to 0 on start
        clear_counts();
        start_load(4'd0);
        for (int i = 0; i < 16; i++) begin
            pat = {8'hC0 | 8'(i), 8'(i), 8'h5A, ~8'(i)};
            exp_q.push_back({4'(i), pat});
            send_word(pat, 0);
        end
        send_checksum(csum);
        wait_idle();
        check("t3_we_cnt", we_cnt, 16);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_sb_empty", exp_q.size(), 0);
        check("t3_addr_no_wrap", imem_addr, 15);
        clear_counts();
        exp_q.push_back({4'd0, 32'hDEADBEEF});
        start_load(4'd1);
        check("t3_addr_cleared_by_start", imem_addr, 0);
        send_word(32'hDEADBEEF, 1);
        send_checksum(csum);
        wait_idle();
        check("t3b_we_cnt", we_cnt, 1);
        check("t3b_stall_released", cpu_stall, 0);

        // Reset after the 6th byte, then a full reload
        clear_counts();
        exp_q.push_back({4'd0, 32'h01234567});
        start_load(4'd2);
        send_word(32'h01234567, 0);
        send_byte(8'h89, 0);
        send_byte(8'hAB, 0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midload");
        #3;
        reset_n = 1'b1;
        repeat (2) tick();
        check("t4_stall_held", cpu_stall, 1);
        exp_q.push_back({4'd0, 32'h11223344});
        exp_q.push_back({4'd1, 32'h55667788});
        start_load(4'd2);
        send_word(32'h11223344, 0);
        check("t4_stall_mid_reload", cpu_stall, 1);
        send_word(32'h55667788, 2);
        send_checksum(csum);
        wait_idle();
        check("t4_we_cnt", we_cnt, 3);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_sb_empty", exp_q.size(), 0);
        check("t4_stall_released", cpu_stall, 0);

        // start during RECV is ignored and word_count is not re-sampled
        clear_counts();
        exp_q.push_back({4'd0, 32'hCAFEF00D});
        start_load(4'd1);
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 0);
        word_count = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_state_recv", dbg_state, 1);
        send_byte(8'hF0, 0);
        send_byte(8'h0D, 0);
        send_checksum(csum);
        wait_idle();
        check("t5_we_cnt", we_cnt, 1);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_sb_empty", exp_q.size(), 0);
        check("t5_stall_released", cpu_stall, 0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // AA^BB^CC^DD = 00
        clear_counts();
        exp_q.push_back({4'd0, 32'hAABBCCDD});
        start_load(4'd1);
        send_word(32'hAABBCCDD, 0);
        send_byte(8'h00, 0);
        wait_idle();
        check("t6_good_chk_err", chk_err, 0);
        check("t6_good_stall", cpu_stall, 0);
        check("t6_good_done", done_cnt, 1);
        clear_counts();
        exp_q.push_back({4'd0, 32'hAABBCCDD});
        start_load(4'd1);
        send_word(32'hAABBCCDD, 0);
        send_byte(8'h01, 0);
        wait_idle();
        check("t6_bad_chk_err", chk_err, 1);
        check("t6_bad_stall", cpu_stall, 1);
        check("t6_bad_done", done_cnt, 1);
        repeat (3) tick();
        check("t6_chk_err_sticky", chk_err, 1);
        start_load(4'd1);
        check("t6_chk_err_cleared", chk_err, 0);
        exp_q.push_back({4'd0, 32'h0000FFFF});
        send_word(32'h0000FFFF, 0);
        send_byte(8'h00, 0);
        wait_idle();
        check("t6_recover_stall", cpu_stall, 0);
`else
        check("t6_chk_err_tied", chk_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
